i_fetch_buffer: RTL and testbench
=================================

Name: i_fetch_buffer

Overview:
- Instruction fetch stage directly upstream of the instruction-memory interface.
- Generates sequential fetch addresses, drives the memory read port, and tracks the memory's fixed 1-cycle read latency.
- Buffers returned words in a small FIFO and presents {instruction, pc} to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing buffered and in-flight work.

Parameters:
- DATA_WIDTH, 32: instruction word width.
- ADDRESS_BITS, 11: word-address width. All PCs in this block are word addresses; the core converts to and from byte addresses.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, at least 2.
- RESET_PC, 0: first word address fetched after reset.

Ports:
- clock, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- fetch_enable, in, 1: when low, no new reads are issued; an in-flight read still completes.
- redirect_valid, in, 1: flush request and new fetch target.
- redirect_pc, in, ADDRESS_BITS: redirect target word address.
- mem_read, out, 1: read request to instruction memory.
- mem_write, out, 1: tied 0.
- mem_address, out, ADDRESS_BITS: read address.
- mem_in_data, out, DATA_WIDTH: tied 0.
- mem_out_data, in, DATA_WIDTH: read data, valid exactly 1 cycle after mem_read.
- inst_valid, out, 1: FIFO head valid.
- inst_ready, in, 1: decode accepts the head.
- inst_data, out, DATA_WIDTH: head instruction.
- inst_pc, out, ADDRESS_BITS: head word address.
- occupancy, out, log2(FIFO_DEPTH)+1: current FIFO entry count.

Behaviour:
- Reset state (asserted): fetch_pc=RESET_PC, FIFO empty, in-flight flag clear, mem_read=0, inst_valid=0, occupancy=0.
- Issue condition: issue = fetch_enable & (occupancy + inflight - pop < FIFO_DEPTH), where pop = inst_valid & inst_ready.
  - Credit counting guarantees a response always has a free slot, so responses are never dropped for lack of space.
- Normal issue: mem_read=issue, mem_address=fetch_pc.
  - On issue: fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDRESS_BITS (the word at all-ones is followed by 0).
  - In-flight register <= {1, fetch_pc}.
- Response: in the cycle after an issue, mem_out_data plus the in-flight pc are pushed into the FIFO. The in-flight flag clears unless a new issue occurs in that same cycle.
- Throughput: one instruction per cycle sustained when decode is always ready.
- Latency: reset released with issue at cycle 0 → pushed at cycle 1 → inst_valid at cycle 2.
- Output: inst_valid = occupancy!=0; inst_data/inst_pc come from the head entry. Head fields must remain stable while inst_valid & !inst_ready.
- Simultaneous push and pop: both take effect and occupancy is unchanged. This is legal when full, since the credit rule already reserved the slot.
- Redirect (redirect_valid=1) overrides everything in that cycle:
  - FIFO cleared; any pop that cycle is ignored.
  - The response arriving this cycle (stale) is discarded.
  - mem_read=1 and mem_address=redirect_pc in the same cycle, provided fetch_enable=1; then fetch_pc <= redirect_pc+1.
  - If fetch_enable=0: no issue, fetch_pc <= redirect_pc, in-flight flag cleared.
  - No epoch tag is needed because the stale response always lands in the redirect cycle itself.
- Back-to-back redirects: each one flushes, and the last one wins.
- fetch_enable low mid-stream: the outstanding response is still pushed; the FIFO drains normally.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously); FIFO contents become don't-care.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined: when the FIFO is empty, a response is valid, and no redirect is active, that response drives inst_valid/inst_data/inst_pc combinationally in the same cycle.
  - If inst_ready=1, the response is consumed and not written to the FIFO; otherwise it is pushed.
  - First-instruction latency after reset becomes 1 cycle.
- Undefined: all responses pass through the FIFO (latency 2, fully registered outputs).

Decomposition:
- Shared package/header holds:
  - fetch constants: RESET_PC default, FIFO_DEPTH default;
  - the occupancy width function (clog2);
  - the fetch-entry bundle layout {pc, data}.
- One natural sub-module: fetch_fifo, a synchronous FIFO of ADDRESS_BITS+DATA_WIDTH bits with push/pop/clear/count.
- Issue logic, in-flight tracking and redirect handling stay in i_fetch_buffer.

Test Plan:
- Streaming: memory preloaded with word n at address n, inst_ready=1 → inst_pc 0,1,2,… on consecutive cycles, inst_data matches, first inst_valid at cycle 2 (cycle 1 with IFETCH_BYPASS_EN).
- Backpressure: inst_ready=0 for 10 cycles → occupancy saturates at 4, mem_read drops to 0, head stays pc=0. Release → pcs 0..5 delivered in order, none lost or duplicated.
- Redirect: redirect_valid with redirect_pc=0x40 while streaming and FIFO holding 3 entries → same cycle mem_address=0x40. The next delivered inst_pc is 0x40, followed by 0x41; no stale pcs appear.
- Redirect while full and stalled, with simultaneous inst_ready=1 → pop ignored, FIFO empty next cycle, next valid pc = redirect_pc.
- Wrap: redirect_pc=0x7FE (ADDRESS_BITS=11) → delivered pcs 0x7FE, 0x7FF, 0x000.
- Async reset mid-stream: drive reset low between clock edges → inst_valid=0 and mem_read=0 immediately. After release, fetch restarts at RESET_PC=0.

Source files
------------

// File: rtl/i_fetch_buffer_pkg.sv
// Shared fetch constants, sizing helpers and the buffer entry layout.
package i_fetch_buffer_pkg;

    localparam int unsigned DefaultResetPc   = 0;
    localparam int unsigned DefaultFifoDepth = 4;

    // Occupancy needs one extra bit so that a full FIFO (count == depth) is representable.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Buffer entries are packed as {pc, data}: pc in the upper bits, data in the lower bits.
    function automatic int unsigned entry_width(input int unsigned addr_bits,
                                                input int unsigned data_width);
        return addr_bits + data_width;
    endfunction

endpackage

// File: rtl/i_fetch_buffer_if.sv
// Memory-port and decode-port bundle of the fetch buffer.
// The master modport is the fetch buffer, the slave modport is its environment.
interface i_fetch_buffer_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 11,
    parameter int unsigned FIFO_DEPTH   = 4
);
    import i_fetch_buffer_pkg::*;

    localparam int unsigned OccWidth = occ_width(FIFO_DEPTH);

    logic                    fetch_enable;
    logic                    redirect_valid;
    logic [ADDRESS_BITS-1:0] redirect_pc;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDRESS_BITS-1:0] mem_address;
    logic [DATA_WIDTH-1:0]   mem_in_data;
    logic [DATA_WIDTH-1:0]   mem_out_data;
    logic                    inst_valid;
    logic                    inst_ready;
    logic [DATA_WIDTH-1:0]   inst_data;
    logic [ADDRESS_BITS-1:0] inst_pc;
    logic [OccWidth-1:0]     occupancy;

    modport master (
        input  fetch_enable, redirect_valid, redirect_pc, mem_out_data, inst_ready,
        output mem_read, mem_write, mem_address, mem_in_data,
        output inst_valid, inst_data, inst_pc, occupancy
    );

    modport slave (
        output fetch_enable, redirect_valid, redirect_pc, mem_out_data, inst_ready,
        input  mem_read, mem_write, mem_address, mem_in_data,
        input  inst_valid, inst_data, inst_pc, occupancy
    );

endinterface

// File: rtl/i_fetch_buffer_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, data} entries, with push/pop/clear and a live count.
// A push and a pop in the same cycle while full is legal: the write lands on the slot being freed.
module i_fetch_buffer_fetch_fifo
    import i_fetch_buffer_pkg::*;
#(
    parameter int unsigned Width = 43,
    parameter int unsigned Depth = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        clear_i,
    input  logic [Width-1:0]            wdata_i,
    output logic [Width-1:0]            rdata_o,
    output logic [occ_width(Depth)-1:0] count_o
);
    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = occ_width(Depth);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;

    // Pointer and count next-state; clear wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
            count_d = count_q + CntWidth'(push_i) - CntWidth'(pop_i);
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset or clear.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/i_fetch_buffer.sv
// Instruction fetch buffer: issues sequential word reads to a 1-cycle-latency memory, buffers
// the responses and hands {instruction, pc} to decode. Redirects flush buffered and in-flight
// work. Define IFETCH_BYPASS_EN to let a response reach decode in its arrival cycle when the
// buffer is empty.
module i_fetch_buffer
    import i_fetch_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 11,
    parameter int unsigned FIFO_DEPTH   = DefaultFifoDepth,
    parameter int unsigned RESET_PC     = DefaultResetPc
) (
    input logic              clock,
    input logic              reset,
    i_fetch_buffer_if.master bus
);
    localparam int unsigned OccWidth   = occ_width(FIFO_DEPTH);
    localparam int unsigned EntryWidth = entry_width(ADDRESS_BITS, DATA_WIDTH);

    logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic                    inflight_q, inflight_d;
    logic [ADDRESS_BITS-1:0] inflight_pc_q, inflight_pc_d;

    logic                    issue, pop, bypass;
    logic                    fifo_push, fifo_pop, fifo_clear;
    logic [OccWidth-1:0]     fifo_count;
    logic [EntryWidth-1:0]   fifo_wdata, fifo_rdata;
    logic [OccWidth:0]       credit;
    logic [ADDRESS_BITS-1:0] issue_addr;

    // Decode-side view: FIFO head, or the arriving response when bypass applies.
    always_comb begin
`ifdef IFETCH_BYPASS_EN
        bypass = (fifo_count == '0) && inflight_q && !bus.redirect_valid;
`else
        bypass = 1'b0;
`endif
        bus.inst_valid = bypass || (fifo_count != '0);
        bus.inst_data  = bypass ? bus.mem_out_data : fifo_rdata[DATA_WIDTH-1:0];
        bus.inst_pc    = bypass ? inflight_pc_q : fifo_rdata[EntryWidth-1 -: ADDRESS_BITS];
        bus.occupancy  = fifo_count;
        pop            = bus.inst_valid && bus.inst_ready;
    end

    // Issue decision, fetch/in-flight next-state and FIFO control.
    always_comb begin
        // Slots already promised: buffered entries plus the read in flight, minus this pop.
        credit = {1'b0, fifo_count} + (OccWidth + 1)'(inflight_q) - (OccWidth + 1)'(pop);
        if (bus.redirect_valid) begin
            issue      = bus.fetch_enable;
            issue_addr = bus.redirect_pc;
        end else begin
            issue      = bus.fetch_enable && (credit < (OccWidth + 1)'(FIFO_DEPTH));
            issue_addr = fetch_pc_q;
        end
        if (!reset) issue = 1'b0;

        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid && !bus.fetch_enable) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (issue) begin
            fetch_pc_d = issue_addr + ADDRESS_BITS'(1);
        end
        inflight_d    = issue;
        inflight_pc_d = issue ? issue_addr : inflight_pc_q;

        // A response arriving in a redirect cycle is stale and dropped.
        fifo_clear = bus.redirect_valid;
        fifo_push  = inflight_q && !bus.redirect_valid && !(bypass && bus.inst_ready);
        fifo_pop   = pop && !bus.redirect_valid && !bypass;
        fifo_wdata = {inflight_pc_q, bus.mem_out_data};
    end

    // Fetch PC and in-flight tracking registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= ADDRESS_BITS'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign bus.mem_read    = issue;
    assign bus.mem_address = issue_addr;
    assign bus.mem_write   = 1'b0;
    assign bus.mem_in_data = '0;

    i_fetch_buffer_fetch_fifo #(
        .Width (EntryWidth),
        .Depth (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clear_i (fifo_clear),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_i_fetch_buffer.sv
// Directed bench for i_fetch_buffer with a 1-cycle-latency memory model (word at address a is
// 0xC0DE0000 | a). Works with or without IFETCH_BYPASS_EN.
module tb_i_fetch_buffer;
    import i_fetch_buffer_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AB = 11;
    localparam int unsigned FD = 4;
`ifdef IFETCH_BYPASS_EN
    localparam int FirstValid = 1;
`else
    localparam int FirstValid = 2;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    i_fetch_buffer_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .FIFO_DEPTH(FD)) bus ();

    i_fetch_buffer #(
        .DATA_WIDTH   (DW),
        .ADDRESS_BITS (AB),
        .FIFO_DEPTH   (FD),
        .RESET_PC     (0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mem_word(input logic [AB-1:0] a);
        return 32'hC0DE_0000 | {21'b0, a};
    endfunction

    always @(posedge clock) begin
        if (bus.mem_read) bus.mem_out_data <= mem_word(bus.mem_address);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        bus.fetch_enable = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.fetch_enable = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if (bus.mem_read !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_read: got %0b expected 0", bus.mem_read);
        end
        n_checks++;
        if (bus.inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_inst_valid: got %0b expected 0", bus.inst_valid);
        end
        n_checks++;
        if (bus.occupancy !== 3'd0) begin
            n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy);
        end
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_address !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_first_issue: got read=%0b addr=%0h expected read=1 addr=0",
                     bus.mem_read, bus.mem_address);
        end
    endtask

    task automatic test_streaming();
        logic [AB-1:0] exp_pc;
        apply_reset();
        bus.fetch_enable = 1'b1;
        bus.inst_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            n_checks++;
            if (bus.mem_read !== 1'b1 || bus.mem_address !== AB'(c)) begin
                n_fail++;
                $display("FAIL stream_issue c%0d: got read=%0b addr=%0h expected read=1 addr=%0h",
                         c, bus.mem_read, bus.mem_address, c);
            end
            n_checks++;
            if (bus.inst_valid !== (c >= FirstValid)) begin
                n_fail++;
                $display("FAIL stream_valid c%0d: got %0b expected %0b",
                         c, bus.inst_valid, c >= FirstValid);
            end
            if (c >= FirstValid) begin
                exp_pc = AB'(c - FirstValid);
                n_checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL stream_head c%0d: got pc=%0h data=%0h expected pc=%0h data=%0h",
                             c, bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [AB-1:0] exp_pc;
        int got;
        apply_reset();
        bus.fetch_enable = 1'b1;
        bus.inst_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++;
            if (bus.inst_valid !== (c >= FirstValid) ||
                (c >= FirstValid && bus.inst_pc !== 11'h000)) begin
                n_fail++;
                $display("FAIL stall_head c%0d: got valid=%0b pc=%0h expected valid=%0b pc=0",
                         c, bus.inst_valid, bus.inst_pc, c >= FirstValid);
            end
            tick();
        end
        #1;
        n_checks++;
        if (bus.occupancy !== 3'd4) begin
            n_fail++; $display("FAIL stall_occupancy: got %0d expected 4", bus.occupancy);
        end
        n_checks++;
        if (bus.mem_read !== 1'b0) begin
            n_fail++; $display("FAIL stall_mem_read: got %0b expected 0", bus.mem_read);
        end
        bus.inst_ready = 1'b1;
        exp_pc = '0;
        got = 0;
        for (int i = 0; i < 12 && got < 6; i++) begin
            #1;
            if (bus.inst_valid) begin
                n_checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL drain_order: got pc=%0h data=%0h expected pc=%0h data=%0h",
                             bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got != 6) begin
            n_fail++; $display("FAIL drain_count: got %0d expected 6", got);
        end
    endtask

    task automatic test_redirect();
        logic [AB-1:0] exp_pc;
        int got;
        apply_reset();
        bus.fetch_enable = 1'b1;
        bus.inst_ready = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #1;
        n_checks++;
        if (bus.occupancy !== 3'd3) begin
            n_fail++; $display("FAIL redir_pre_occupancy: got %0d expected 3", bus.occupancy);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 11'h040;
        bus.inst_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_address !== 11'h040) begin
            n_fail++;
            $display("FAIL redir_issue: got read=%0b addr=%0h expected read=1 addr=40",
                     bus.mem_read, bus.mem_address);
        end
        tick();
        bus.redirect_valid = 1'b0;
        exp_pc = 11'h040;
        got = 0;
        for (int i = 0; i < 10 && got < 3; i++) begin
            #1;
            if (bus.inst_valid) begin
                n_checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL redir_stream: got pc=%0h data=%0h expected pc=%0h data=%0h",
                             bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got != 3) begin
            n_fail++; $display("FAIL redir_count: got %0d expected 3", got);
        end
    endtask

    task automatic test_redirect_full();
        int seen;
        apply_reset();
        bus.fetch_enable = 1'b1;
        bus.inst_ready = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        #1;
        n_checks++;
        if (bus.occupancy !== 3'd4) begin
            n_fail++; $display("FAIL full_occupancy: got %0d expected 4", bus.occupancy);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 11'h123;
        bus.inst_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_address !== 11'h123) begin
            n_fail++;
            $display("FAIL full_redir_issue: got read=%0b addr=%0h expected read=1 addr=123",
                     bus.mem_read, bus.mem_address);
        end
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.occupancy !== 3'd0) begin
            n_fail++; $display("FAIL full_flush: got occupancy %0d expected 0", bus.occupancy);
        end
        seen = 0;
        for (int i = 0; i < 6 && seen == 0; i++) begin
            if (i > 0) #1;
            if (bus.inst_valid) begin
                seen = 1;
                n_checks++;
                if (bus.inst_pc !== 11'h123) begin
                    n_fail++;
                    $display("FAIL full_next_pc: got %0h expected 123", bus.inst_pc);
                end
            end
            tick();
        end
        n_checks++;
        if (seen == 0) begin
            n_fail++; $display("FAIL full_next_valid: got none expected pc 123");
        end
    endtask

    task automatic test_wrap();
        logic [AB-1:0] exp_pc;
        int got;
        apply_reset();
        bus.fetch_enable = 1'b1;
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 11'h7FE;
        #1;
        n_checks++;
        if (bus.mem_address !== 11'h7FE) begin
            n_fail++; $display("FAIL wrap_issue: got %0h expected 7fe", bus.mem_address);
        end
        tick();
        bus.redirect_valid = 1'b0;
        exp_pc = 11'h7FE;
        got = 0;
        for (int i = 0; i < 10 && got < 4; i++) begin
            #1;
            if (bus.inst_valid) begin
                n_checks++;
                if (bus.inst_pc !== exp_pc || bus.inst_data !== mem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL wrap_stream: got pc=%0h data=%0h expected pc=%0h data=%0h",
                             bus.inst_pc, bus.inst_data, exp_pc, mem_word(exp_pc));
                end
                exp_pc++;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got != 4) begin
            n_fail++; $display("FAIL wrap_count: got %0d expected 4", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [AB-1:0] exp_pc;
        int got;
        apply_reset();
        bus.fetch_enable = 1'b1;
        bus.inst_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 11'h100;
        #1;
        n_checks++;
        if (bus.mem_address !== 11'h100) begin
            n_fail++; $display("FAIL b2b_first_issue: got %0h expected 100", bus.mem_address);
        end
        tick();
        bus.redirect_pc = 11'h200;
        #1;
        n_checks++;
        if (bus.mem_address !== 11'h200) begin
            n_fail++; $display("FAIL b2b_second_issue: got %0h expected 200", bus.mem_address);
        end
        tick();
        bus.redirect_valid = 1'b0;
        exp_pc = 11'h200;
        got = 0;
        for (int i = 0; i < 8 && got < 3; i++) begin
            #1;
            if (bus.inst_valid) begin
                n_checks++;
                if (bus.inst_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL b2b_stream: got pc=%0h expected %0h", bus.inst_pc, exp_pc);
                end
                exp_pc++;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 3", got);
        end
    endtask

    task automatic test_fetch_disable();
        logic [AB-1:0] exp_pc;
        apply_reset();
        bus.fetch_enable = 1'b1;
        bus.inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        bus.fetch_enable = 1'b0;
        exp_pc = AB'(4 - FirstValid);
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (bus.mem_read !== 1'b0) begin
                n_fail++; $display("FAIL dis_mem_read: got %0b expected 0", bus.mem_read);
            end
            if (bus.inst_valid) begin
                n_checks++;
                if (bus.inst_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL dis_drain: got pc=%0h expected %0h", bus.inst_pc, exp_pc);
                end
                exp_pc++;
            end
            tick();
        end
        n_checks++;
        if (exp_pc !== 11'h004 || bus.occupancy !== 3'd0) begin
            n_fail++;
            $display("FAIL dis_drained: got next=%0h occ=%0d expected next=4 occ=0",
                     exp_pc, bus.occupancy);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 11'h055;
        #1;
        n_checks++;
        if (bus.mem_read !== 1'b0) begin
            n_fail++; $display("FAIL dis_redir_read: got %0b expected 0", bus.mem_read);
        end
        tick();
        bus.redirect_valid = 1'b0;
        bus.fetch_enable = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_address !== 11'h055) begin
            n_fail++;
            $display("FAIL dis_resume: got read=%0b addr=%0h expected read=1 addr=55",
                     bus.mem_read, bus.mem_address);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int seen;
        apply_reset();
        bus.fetch_enable = 1'b1;
        bus.inst_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.inst_valid !== 1'b0 || bus.mem_read !== 1'b0 || bus.occupancy !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%0b read=%0b occ=%0d expected 0 0 0",
                     bus.inst_valid, bus.mem_read, bus.occupancy);
        end
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_address !== 11'h000) begin
            n_fail++;
            $display("FAIL async_restart: got read=%0b addr=%0h expected read=1 addr=0",
                     bus.mem_read, bus.mem_address);
        end
        tick();
        seen = 0;
        for (int i = 0; i < 6 && seen == 0; i++) begin
            #1;
            if (bus.inst_valid) begin
                seen = 1;
                n_checks++;
                if (bus.inst_pc !== 11'h000) begin
                    n_fail++;
                    $display("FAIL async_first_pc: got %0h expected 0", bus.inst_pc);
                end
            end
            tick();
        end
        n_checks++;
        if (seen == 0) begin
            n_fail++; $display("FAIL async_first_valid: got none expected pc 0");
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_redirect_full();
        test_wrap();
        test_back_to_back();
        test_fetch_disable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
